// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter: FSM encoding, the fixed
// kseg0/kseg1 segment map and a width helper for the grant index.
package sram_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Top three address bits that select the unmapped kernel segments.
   localparam logic [2:0]  KSEG0     = 3'b100;
   localparam logic [2:0]  KSEG1     = 3'b101;
   // Clearing the segment bits yields the physical address.
   localparam logic [31:0] PHYS_MASK = 32'h1FFF_FFFF;

   // Bits needed to index n channels, never less than one.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_arbiter.sv
// Round-robin request picker: returns the first requesting channel at or
// after ptr (wrapping), both as a one-hot vector and as an index.
module sram_port_arbiter_rr_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int NCH = 2,
   parameter int IW  = clog2_min1(NCH)
) (
   input  logic [NCH-1:0] req,
   input  logic [IW-1:0]  ptr,
   output logic [NCH-1:0] gnt,
   output logic [IW-1:0]  idx,
   output logic           any
);

   // Scan channels starting at ptr; the first hit wins.
   always_comb begin
      int c;
      c   = 0;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 0; k < NCH; k++) begin
         c = (int'(ptr) + k) % NCH;
         if (!any && req[c]) begin
            any    = 1'b1;
            gnt[c] = 1'b1;
            idx    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Merges NCH single-cycle SRAM-style core channels onto one shared memory
// port with an addr_ok/data_ok handshake. Each channel is stalled until its
// access completes; kseg0/kseg1 addresses are folded to physical space.
module sram_port_arbiter
   import sram_port_arbiter_pkg::*;
#(
   parameter int NCH    = 2,
   parameter int AW     = 32,
   parameter int DW     = 32,
   parameter int MMU_EN = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NCH-1:0]              ch_en,
   input  logic [NCH*(DW/8)-1:0]       ch_wen,
   input  logic [NCH*AW-1:0]           ch_addr,
   input  logic [NCH*DW-1:0]           ch_wdata,
   output logic [NCH*DW-1:0]           ch_rdata,
   output logic [NCH-1:0]              ch_stall,
   output logic                        mem_req,
   output logic                        mem_wr,
   output logic [DW/8-1:0]             mem_wstrb,
   output logic [AW-1:0]               mem_addr,
   output logic [DW-1:0]               mem_wdata,
   input  logic                        mem_addr_ok,
   input  logic                        mem_data_ok,
   input  logic [DW-1:0]               mem_rdata,
   output logic                        busy,
   output logic [clog2_min1(NCH)-1:0]  grant_id
);

   localparam int IW = clog2_min1(NCH);
   localparam int SW = DW / 8;

   state_t          state, state_nx;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   ptr_nx;
   logic [NCH-1:0]  arb_gnt;
   logic [IW-1:0]   arb_idx;
   logic            arb_any;
   logic [AW-1:0]   sel_addr;
   logic [SW-1:0]   sel_wen;
   logic [DW-1:0]   sel_wdata;
   logic            do_grant;
   logic            do_accept;
   logic            do_capture;

   // Fixed-map translation: kseg0/kseg1 drop their segment bits.
   function automatic logic [AW-1:0] xlate(input logic [AW-1:0] va);
      logic [AW-1:0] pa;
      pa = va;
      if (MMU_EN != 0 && AW == 32) begin
         if (va[AW-1 -: 3] == KSEG0 || va[AW-1 -: 3] == KSEG1)
            pa = va & AW'(PHYS_MASK);
      end
      return pa;
   endfunction

   sram_port_arbiter_rr_arbiter #(
      .NCH (NCH),
      .IW  (IW)
   ) u_rr (
      .req (ch_en),
      .ptr (rr_ptr),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Select the winning channel's request fields with a one-hot AND-OR mux.
   always_comb begin
      sel_addr  = '0;
      sel_wen   = '0;
      sel_wdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (arb_gnt[i]) begin
            sel_addr  |= ch_addr[i*AW +: AW];
            sel_wen   |= ch_wen[i*SW +: SW];
            sel_wdata |= ch_wdata[i*DW +: DW];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // Next-state logic and the per-cycle datapath strobes.
   always_comb begin
      state_nx   = state;
      do_grant   = 1'b0;
      do_accept  = 1'b0;
      do_capture = 1'b0;
      case (state)
         ST_IDLE: begin
            if (arb_any) begin
               do_grant = 1'b1;
               state_nx = ST_ADDR;
            end
         end
         ST_ADDR: begin
            // data_ok is meaningless until the address has been accepted
            if (mem_addr_ok) begin
               do_accept = 1'b1;
               if (mem_data_ok) begin
                  do_capture = ~mem_wr;
                  state_nx   = ST_DONE;
               end else begin
                  state_nx   = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (mem_data_ok) begin
               do_capture = ~mem_wr;
               state_nx   = ST_DONE;
            end
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Channel after the one just served becomes top priority.
   always_comb begin
      ptr_nx = (grant_id == IW'(NCH - 1)) ? '0 : grant_id + 1'b1;
   end

   // Memory-side request registers, grant bookkeeping and read-data capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_id  <= '0;
         rr_ptr    <= '0;
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_wstrb <= '0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         ch_rdata  <= '0;
      end else begin
         if (do_grant) begin
            grant_id  <= arb_idx;
            mem_req   <= 1'b1;
            mem_wr    <= |sel_wen;
            mem_wstrb <= sel_wen;
            mem_addr  <= xlate(sel_addr);
            mem_wdata <= sel_wdata;
         end
         if (do_accept)
            mem_req <= 1'b0;
         if (do_capture)
            ch_rdata[int'(grant_id)*DW +: DW] <= mem_rdata;
         if (state == ST_DONE)
            rr_ptr <= ptr_nx;
      end
   end

   // A requester is released only in the DONE cycle of its own access.
   always_comb begin
      ch_stall = ch_en;
      for (int i = 0; i < NCH; i++) begin
         if (state == ST_DONE && grant_id == IW'(i))
            ch_stall[i] = 1'b0;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized self-checking bench for sram_port_arbiter. The bench plays the
// memory and keeps a transaction-level model of arbitration, translation and
// per-channel read data. A second instance with the fixed map disabled runs
// in lockstep on the same inputs.
module tb_sram_port_arbiter;

   localparam int NCH = 2;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int SW  = DW / 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic [NCH-1:0]       ch_en;
   logic [NCH*SW-1:0]    ch_wen;
   logic [NCH*AW-1:0]    ch_addr;
   logic [NCH*DW-1:0]    ch_wdata;
   logic [NCH*DW-1:0]    ch_rdata, pt_ch_rdata;
   logic [NCH-1:0]       ch_stall, pt_ch_stall;
   logic                 mem_req, pt_mem_req;
   logic                 mem_wr, pt_mem_wr;
   logic [SW-1:0]        mem_wstrb, pt_mem_wstrb;
   logic [AW-1:0]        mem_addr, pt_mem_addr;
   logic [DW-1:0]        mem_wdata, pt_mem_wdata;
   logic                 mem_addr_ok, mem_data_ok;
   logic [DW-1:0]        mem_rdata;
   logic                 busy, pt_busy;
   logic [0:0]           grant_id, pt_grant_id;

   int                   n_tests, n_fail;
   int                   m_ptr;
   logic [DW-1:0]        m_rd     [NCH];
   logic [NCH-1:0]       tx_en;
   logic [AW-1:0]        tx_addr  [NCH];
   logic [SW-1:0]        tx_wen   [NCH];
   logic [DW-1:0]        tx_wdata [NCH];
   bit                   scr;
   int                   g;

   always #5 clk = ~clk;

   sram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MMU_EN(1)) u_dut (
      .clk(clk), .rst(rst), .ch_en(ch_en), .ch_wen(ch_wen), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_rdata(ch_rdata), .ch_stall(ch_stall),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(busy),
      .grant_id(grant_id)
   );

   sram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MMU_EN(0)) u_dut_pt (
      .clk(clk), .rst(rst), .ch_en(ch_en), .ch_wen(ch_wen), .ch_addr(ch_addr),
      .ch_wdata(ch_wdata), .ch_rdata(pt_ch_rdata), .ch_stall(pt_ch_stall),
      .mem_req(pt_mem_req), .mem_wr(pt_mem_wr), .mem_wstrb(pt_mem_wstrb),
      .mem_addr(pt_mem_addr), .mem_wdata(pt_mem_wdata), .mem_addr_ok(mem_addr_ok),
      .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .busy(pt_busy),
      .grant_id(pt_grant_id)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Fixed kseg0/kseg1 map: segments 3'b100 and 3'b101 lose their top bits.
   function automatic logic [AW-1:0] ref_xlate(input logic [AW-1:0] va);
      if (va[31:29] == 3'b100 || va[31:29] == 3'b101) return {3'b000, va[28:0]};
      return va;
   endfunction

   // First requesting channel at or after ptr, wrapping.
   function automatic int ref_pick(input logic [NCH-1:0] en, input int ptr);
      for (int k = 0; k < NCH; k++) begin
         if (en[(ptr + k) % NCH]) return (ptr + k) % NCH;
      end
      return 0;
   endfunction

   function automatic logic [NCH*DW-1:0] rd_exp();
      logic [NCH*DW-1:0] r;
      for (int i = 0; i < NCH; i++) r[i*DW +: DW] = m_rd[i];
      return r;
   endfunction

   task automatic drive_tx();
      ch_en = tx_en;
      for (int i = 0; i < NCH; i++) begin
         ch_addr[i*AW +: AW]  = tx_addr[i];
         ch_wen[i*SW +: SW]   = tx_wen[i];
         ch_wdata[i*DW +: DW] = tx_wdata[i];
      end
   endtask

   // Core-side inputs may wander while stalled; the DUT must ignore them.
   task automatic scramble();
      if (scr) begin
         ch_en    = NCH'($urandom);
         ch_addr  = {$urandom(), $urandom()};
         ch_wen   = (NCH*SW)'($urandom);
         ch_wdata = {$urandom(), $urandom()};
      end
   endtask

   task automatic rand_tx();
      tx_en = NCH'($urandom_range(1, (1 << NCH) - 1));
      for (int i = 0; i < NCH; i++) begin
         tx_addr[i]  = {3'($urandom_range(0, 7)), 29'($urandom)};
         tx_wen[i]   = ($urandom_range(0, 1) == 1) ? SW'($urandom) : '0;
         tx_wdata[i] = $urandom;
      end
   endtask

   task automatic idle_gap(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ch_en       = '0;
         mem_addr_ok = 1'($urandom);
         mem_data_ok = 1'($urandom);
         mem_rdata   = $urandom;
         #1;
         chk("idle_busy", busy, 0);
         chk("idle_req", mem_req, 0);
         chk("idle_stall", ch_stall, 0);
         chk("idle_rdata", ch_rdata, rd_exp());
      end
   endtask

   // One access from the IDLE cycle through DONE. a_dly = cycles before
   // addr_ok, d_dly = cycles from addr_ok to data_ok (0 = same cycle).
   task automatic run_xact(input int a_dly, input int d_dly, input bit spur,
                           input logic [DW-1:0] rd, input bit rst_in_data,
                           output int gi);
      logic [AW-1:0]  raw;
      logic [SW-1:0]  e_wen;
      logic [DW-1:0]  e_wd;
      logic           is_wr;
      logic [NCH-1:0] e_st;
      gi    = ref_pick(tx_en, m_ptr);
      raw   = tx_addr[gi];
      e_wen = tx_wen[gi];
      e_wd  = tx_wdata[gi];
      is_wr = |e_wen;

      @(negedge clk);
      drive_tx();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
      #1;
      chk("arb_busy", busy, 0);
      chk("arb_stall", ch_stall, ch_en);
      chk("arb_rdata", ch_rdata, rd_exp());

      for (int k = 0; k <= a_dly; k++) begin
         @(negedge clk);
         scramble();
         mem_addr_ok = (k == a_dly);
         mem_data_ok = (k == a_dly) ? (d_dly == 0) : spur;
         mem_rdata   = (k == a_dly && d_dly == 0) ? rd : $urandom;
         #1;
         chk("req", mem_req, 1);
         chk("addr", mem_addr, ref_xlate(raw));
         chk("wr", mem_wr, is_wr);
         chk("wstrb", mem_wstrb, e_wen);
         chk("wdata", mem_wdata, e_wd);
         chk("gid", grant_id, gi);
         chk("busy", busy, 1);
         chk("stall", ch_stall, ch_en);
         chk("pt_req", pt_mem_req, 1);
         chk("pt_addr", pt_mem_addr, raw);
         chk("pt_wr", pt_mem_wr, is_wr);
         chk("pt_wstrb", pt_mem_wstrb, e_wen);
         chk("pt_wdata", pt_mem_wdata, e_wd);
         chk("pt_gid", pt_grant_id, gi);
      end

      for (int k = 1; k <= d_dly; k++) begin
         @(negedge clk);
         if (rst_in_data) begin
            rst         = 1'b1;
            mem_data_ok = 1'b0;
            #1;
            for (int i = 0; i < NCH; i++) m_rd[i] = '0;
            m_ptr = 0;
            chk("rst_busy", busy, 0);
            chk("rst_req", mem_req, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_wr", mem_wr, 0);
            chk("rst_wstrb", mem_wstrb, 0);
            chk("rst_wdata", mem_wdata, 0);
            chk("rst_gid", grant_id, 0);
            chk("rst_rdata", ch_rdata, rd_exp());
            @(negedge clk);
            rst         = 1'b0;
            ch_en       = '0;
            mem_data_ok = 1'b1;
            mem_rdata   = $urandom;
            #1;
            chk("stray_busy", busy, 0);
            @(negedge clk);
            mem_data_ok = 1'b0;
            #1;
            chk("stray_busy2", busy, 0);
            chk("stray_req", mem_req, 0);
            chk("stray_rdata", ch_rdata, rd_exp());
            return;
         end
         scramble();
         mem_addr_ok = 1'b0;
         mem_data_ok = (k == d_dly);
         mem_rdata   = (k == d_dly) ? rd : $urandom;
         #1;
         chk("data_req", mem_req, 0);
         chk("data_busy", busy, 1);
         chk("data_stall", ch_stall, ch_en);
         chk("data_gid", grant_id, gi);
      end

      if (!is_wr) m_rd[gi] = rd;
      @(negedge clk);
      scramble();
      mem_addr_ok = 1'b0;
      mem_data_ok = 1'($urandom);
      mem_rdata   = $urandom;
      #1;
      e_st     = ch_en;
      e_st[gi] = 1'b0;
      chk("done_stall", ch_stall, e_st);
      chk("done_busy", busy, 1);
      chk("done_rdata", ch_rdata, rd_exp());
      chk("pt_stall", pt_ch_stall, e_st);
      chk("pt_busy", pt_busy, 1);
      chk("pt_rdata", pt_ch_rdata, rd_exp());
      m_ptr = (gi + 1) % NCH;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev;
      n_tests = 0;
      n_fail  = 0;
      m_ptr   = 0;
      scr     = 1'b0;
      for (int i = 0; i < NCH; i++) m_rd[i] = '0;
      rst = 1'b1;
      ch_en = '0; ch_wen = '0; ch_addr = '0; ch_wdata = '0;
      mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_req", mem_req, 0);
      chk("reset_wr", mem_wr, 0);
      chk("reset_wstrb", mem_wstrb, 0);
      chk("reset_addr", mem_addr, 0);
      chk("reset_wdata", mem_wdata, 0);
      chk("reset_rdata", ch_rdata, 0);
      chk("reset_gid", grant_id, 0);
      chk("reset_stall", ch_stall, 0);
      @(negedge clk);
      rst = 1'b0;

      // Minimum-latency read on the data channel through kseg0.
      tx_en = 2'b10;
      tx_addr[0] = 32'h0; tx_wen[0] = '0; tx_wdata[0] = '0;
      tx_addr[1] = 32'h8000_1000; tx_wen[1] = '0; tx_wdata[1] = 32'h0;
      run_xact(0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, g);
      chk("rd_value", ch_rdata[63:32], 32'hDEAD_BEEF);
      chk("rd_maddr", mem_addr, 32'h0000_1000);

      // Partial write through kseg1 with a slow address accept.
      tx_addr[1] = 32'hA000_0004; tx_wen[1] = 4'b0011; tx_wdata[1] = 32'h1234_5678;
      run_xact(3, 1, 1'b0, 32'h5555_AAAA, 1'b0, g);
      chk("wr_maddr", mem_addr, 32'h0000_0004);
      chk("wr_wstrb", mem_wstrb, 4'b0011);
      chk("wr_keep", ch_rdata[63:32], 32'hDEAD_BEEF);

      // Both channels hammering: grants must alternate.
      tx_en = 2'b11;
      tx_addr[0] = 32'h0040_0000; tx_wen[0] = '0; tx_wdata[0] = 32'h0;
      tx_addr[1] = 32'h0000_0100; tx_wen[1] = '0;
      prev = 1;
      for (int n = 0; n < 4; n++) begin
         run_xact(0, 0, 1'b0, $urandom, 1'b0, g);
         chk("alternate", grant_id, 1 - prev);
         prev = 1 - prev;
      end

      // Translation corner cases.
      tx_en = 2'b01;
      tx_addr[0] = 32'hBFC0_0000;
      run_xact(1, 0, 1'b0, $urandom, 1'b0, g);
      chk("mmu_bfc", mem_addr, 32'h1FC0_0000);
      chk("pt_bfc", pt_mem_addr, 32'hBFC0_0000);
      tx_addr[0] = 32'h0040_0000;
      run_xact(0, 2, 1'b0, $urandom, 1'b0, g);
      chk("mmu_useg", mem_addr, 32'h0040_0000);
      tx_addr[0] = 32'h8000_0000;
      run_xact(0, 0, 1'b0, $urandom, 1'b0, g);
      chk("pt_k0", pt_mem_addr, 32'h8000_0000);

      // data_ok before addr_ok must be ignored.
      tx_en = 2'b10;
      tx_addr[1] = 32'h0000_2000; tx_wen[1] = '0;
      run_xact(3, 1, 1'b1, 32'hCAFE_F00D, 1'b0, g);
      chk("spur_value", ch_rdata[63:32], 32'hCAFE_F00D);

      // Reset while waiting for read data, then a stray data_ok.
      tx_en = 2'b01;
      tx_addr[0] = 32'h0000_3000; tx_wen[0] = '0;
      run_xact(0, 3, 1'b0, $urandom, 1'b1, g);

      // Randomized traffic.
      scr = 1'b1;
      for (int n = 0; n < 300; n++) begin
         rand_tx();
         run_xact($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  $urandom, 1'b0, g);
         if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Parametrised successor to the fixed inst/data SRAM hookup of the CPU top level.
- Merges NCH core-side single-cycle SRAM-style channels onto one shared memory port with variable latency and an addr_ok/data_ok handshake.
- Generates a per-channel stall for the pipeline controller.
- Applies the kseg0/kseg1 fixed-map address translation per channel; CPU top instantiates it between mycpu_core and the memory fabric.

Parameters:
NCH, 2, number of core-side channels (1..8); channel 0 = instruction, 1 = data
AW, 32, address width
DW, 32, data width; byte strobes are DW/8
MMU_EN, 1, 1 = apply kseg0/kseg1 fixed map (legal only with AW=32); 0 = pass-through

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
ch_en  in  NCH  channel i requests an access
ch_wen  in  NCH*DW/8  byte write strobes; all-zero = read
ch_addr  in  NCH*AW  virtual byte address
ch_wdata  in  NCH*DW  write data
ch_rdata  out  NCH*DW  registered read data, per channel
ch_stall  out  NCH  channel i must hold its request stable
mem_req  out  1  request valid
mem_wr  out  1  1 = write
mem_wstrb  out  DW/8  byte strobes
mem_addr  out  AW  physical address
mem_wdata  out  DW  write data
mem_addr_ok  in  1  request accepted
mem_data_ok  in  1  read data valid / write complete
mem_rdata  in  DW  read data
busy  out  1  FSM not in IDLE
grant_id  out  clog2(NCH) (min 1)  channel currently owning the port

Behaviour:
- Reset values:
  - state IDLE, rr_ptr 0, grant_id 0.
  - mem_req 0, mem_wr 0, mem_wstrb 0, mem_addr 0, mem_wdata 0.
  - All ch_rdata 0, busy 0.
- ch_stall[i] = ch_en[i] & ~(state==DONE & grant_id==i). Combinational, so it is high in the same cycle a request appears.
- FSM IDLE:
  - If any ch_en, pick the first requesting channel at or after rr_ptr, wrapping modulo NCH.
  - Latch grant_id, translated addr, wstrb and wdata into the mem_* registers.
  - Set mem_req=1 and mem_wr=|wstrb; go to ADDR.
  - If no ch_en, stay in IDLE.
- FSM ADDR:
  - Hold mem_* stable until mem_addr_ok.
  - On mem_addr_ok, clear mem_req; go to DATA, or straight to DONE if mem_data_ok is high in the same cycle.
  - mem_data_ok without mem_addr_ok is ignored.
- FSM DATA: wait for mem_data_ok, then go to DONE. For reads, capture mem_rdata into ch_rdata[grant_id] on that edge.
- FSM DONE:
  - One cycle; the granted channel's stall is low.
  - rr_ptr = grant_id+1, wrapping NCH-1→0.
  - Next state is IDLE.
- Minimum access: request seen in cycle 0; mem_req in cycle 1; addr_ok and data_ok in cycle 1; DONE in cycle 2. That is 2 stall cycles, with data visible in cycle 2.
- ch_rdata[i] holds its value until the next read completion on channel i. Writes never modify ch_rdata.
- The core-side request is sampled only at grant. Changes to it while stalled are ignored.
- If ch_en drops mid-transaction, the memory transaction still completes and DONE still occurs; no abort.
- Translation (MMU_EN=1): addr[31:29] equal to 3'b100 or 3'b101 maps to {3'b000, addr[28:0]}; all other addresses pass through unchanged.
- Fairness: a channel that just completed has lowest priority in the next arbitration. Worst-case wait is NCH-1 transactions.
- Reset asserted mid-operation: immediately returns all state to reset values. A late mem_data_ok arriving in IDLE is ignored.
- NCH=1: arbitration degenerates; grant_id is constant 0.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, ADDR, DATA, DONE);
  - KSEG0/KSEG1 segment constants and the physical mask;
  - a clog2 helper for the grant_id width.
- One natural sub-module: rr_arbiter. It is combinational, taking request vector + rr_ptr and returning a one-hot grant + index.

Test Plan:
- Single read, ch1 addr 0x8000_1000, addr_ok and data_ok both in cycle 1 with rdata 0xDEADBEEF → mem_addr 0x0000_1000, ch_stall[1] high for 2 cycles, ch_rdata[1]=0xDEADBEEF.
- Write ch1 addr 0xA000_0004, wen 4'b0011, wdata 0x1234_5678, addr_ok delayed 3 cycles → mem_wr=1, mem_wstrb=4'b0011, mem_addr 0x0000_0004, mem_req held 4 cycles, ch_rdata[1] unchanged.
- ch0 and ch1 request continuously, NCH=2, fixed 1-cycle memory → grants alternate 0,1,0,1 and each stall clears on alternate DONE cycles.
- Address 0xBFC0_0000 with MMU_EN=1 → 0x1FC0_0000; address 0x0040_0000 passes through unchanged; with MMU_EN=0, 0x8000_0000 passes through unchanged.
- mem_data_ok pulsed in ADDR without addr_ok → ignored, no DONE; a later addr_ok followed by data_ok completes normally.
- rst asserted while in DATA → mem_req 0, busy 0, ch_rdata 0, state IDLE; the subsequent stray data_ok causes no state change.
